// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch time base: 1/100 s tick divider plus a six-digit BCD MM:SS.hh up/down counter
// with run/stop, lap capture, preset load and a count-down expiry flag.
module stopwatch_bcd_counter #(
  parameter int unsigned CLK_DIV = 500000,
  parameter int unsigned DIV_W   = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        dir,
  input  logic        load,
  input  logic [23:0] load_val,
  output logic [23:0] disp,
  output logic        running,
  output logic        lap_active,
  output logic        wrapped,
  output logic        done
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       hs_q, tn_q, su_q, mu_q, mt_q;
  logic [2:0]       st_q;
  logic [23:0]      lap_q, lap_d;
  logic             run_q, run_d;
  logic             lap_act_q, lap_act_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic [23:0]      live, cnt_d, up_val, dn_val, clamp_val;
  logic             tick, up_wrap, dn_zero;

  // Returns {carry, digit} for one BCD digit stepping up with wrap at top.
  function automatic logic [4:0] bcd_up(input logic [3:0] d, input logic ci,
                                        input logic [3:0] top);
    if (!ci) return {1'b0, d};
    if (d == top) return {1'b1, 4'd0};
    return {1'b0, d + 4'd1};
  endfunction

  // Returns {borrow, digit} for one BCD digit stepping down with wrap to top.
  function automatic logic [4:0] bcd_dn(input logic [3:0] d, input logic bi,
                                        input logic [3:0] top);
    if (!bi) return {1'b0, d};
    if (d == 4'd0) return {1'b1, top};
    return {1'b0, d - 4'd1};
  endfunction

  function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] top);
    return (d > top) ? top : d;
  endfunction

  assign live = {mt_q, mu_q, 1'b0, st_q, su_q, tn_q, hs_q};
  assign tick = run_q && (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    logic [4:0] r0, r1, r2, r3, r4, r5;
    r0 = bcd_up(hs_q, 1'b1, 4'd9);
    r1 = bcd_up(tn_q, r0[4], 4'd9);
    r2 = bcd_up(su_q, r1[4], 4'd9);
    r3 = bcd_up({1'b0, st_q}, r2[4], 4'd5);
    r4 = bcd_up(mu_q, r3[4], 4'd9);
    r5 = bcd_up(mt_q, r4[4], 4'd9);
    up_val  = {r5[3:0], r4[3:0], r3[3:0], r2[3:0], r1[3:0], r0[3:0]};
    up_wrap = r5[4];
  end

  always_comb begin
    logic [4:0] b0, b1, b2, b3, b4, b5;
    b0 = bcd_dn(hs_q, 1'b1, 4'd9);
    b1 = bcd_dn(tn_q, b0[4], 4'd9);
    b2 = bcd_dn(su_q, b1[4], 4'd9);
    b3 = bcd_dn({1'b0, st_q}, b2[4], 4'd5);
    b4 = bcd_dn(mu_q, b3[4], 4'd9);
    b5 = bcd_dn(mt_q, b4[4], 4'd9);
    dn_val  = {b5[3:0], b4[3:0], b3[3:0], b2[3:0], b1[3:0], b0[3:0]};
    dn_zero = (dn_val == 24'd0);
  end

  assign clamp_val = {clamp(load_val[23:20], 4'd9), clamp(load_val[19:16], 4'd9),
                      clamp(load_val[15:12], 4'd5), clamp(load_val[11:8], 4'd9),
                      clamp(load_val[7:4], 4'd9), clamp(load_val[3:0], 4'd9)};

  always_comb begin
    cnt_d     = live;
    div_d     = div_q;
    run_d     = run_q;
    lap_act_d = lap_act_q;
    lap_d     = lap_q;
    wrap_d    = 1'b0;
    done_d    = done_q;
    if (clear) begin
      cnt_d     = 24'd0;
      div_d     = '0;
      run_d     = 1'b0;
      lap_act_d = 1'b0;
      lap_d     = 24'd0;
      done_d    = 1'b0;
    end else if (load && !run_q) begin
      cnt_d     = clamp_val;
      div_d     = '0;
      lap_act_d = 1'b0;
      done_d    = 1'b0;
    end else begin
      if (run_q) div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        if (!dir) begin
          cnt_d  = up_val;
          wrap_d = up_wrap;
        end else begin
          cnt_d = dn_val;
          if (dn_zero) begin
            run_d  = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      if (start_stop) begin
        if (run_q) begin
          run_d = 1'b0;
        end else if (!(dir && live == 24'd0)) begin
          run_d  = 1'b1;
          done_d = 1'b0;
        end
      end
      // Split captures the post-tick value so the frozen time never lags the live count.
      if (lap) begin
        if (run_q) begin
          lap_d     = cnt_d;
          lap_act_d = 1'b1;
        end else begin
          lap_act_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      {mt_q, mu_q, su_q, tn_q, hs_q} <= '0;
      st_q      <= '0;
      lap_q     <= 24'd0;
      run_q     <= 1'b0;
      lap_act_q <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      mt_q      <= cnt_d[23:20];
      mu_q      <= cnt_d[19:16];
      st_q      <= cnt_d[14:12];
      su_q      <= cnt_d[11:8];
      tn_q      <= cnt_d[7:4];
      hs_q      <= cnt_d[3:0];
      lap_q     <= lap_d;
      run_q     <= run_d;
      lap_act_q <= lap_act_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
    end
  end

  assign disp       = lap_act_q ? lap_q : live;
  assign running    = run_q;
  assign lap_active = lap_act_q;
  assign wrapped    = wrap_q;
  assign done       = done_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Self-checking bench for stopwatch_bcd_counter: integer-time reference model compared every
// cycle, plus directed literal checks.
module tb_stopwatch_bcd_counter;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned DIV_W   = 3;
  localparam int          TMAX    = 599999;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0, start_stop = 1'b0, lap = 1'b0, dir = 1'b0, load = 1'b0;
  logic [23:0] load_val = 24'd0;
  logic [23:0] disp;
  logic        running, lap_active, wrapped, done;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: time in hundredths of a second.
  int m_t = 0, m_div = 0, m_lap_t = 0;
  bit m_run = 0, m_lap_act = 0, m_wrap = 0, m_done = 0;

  stopwatch_bcd_counter #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .start_stop(start_stop), .lap(lap), .dir(dir),
    .load(load), .load_val(load_val), .disp(disp), .running(running),
    .lap_active(lap_active), .wrapped(wrapped), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int t);
    int m, s, h;
    m = t / 6000;
    s = (t / 100) % 60;
    h = t % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
  endfunction

  function automatic int lim(input logic [3:0] d, input int top);
    return (int'(d) > top) ? top : int'(d);
  endfunction

  function automatic int from_load(input logic [23:0] v);
    int mins, secs, hun;
    mins = lim(v[23:20], 9) * 10 + lim(v[19:16], 9);
    secs = lim(v[15:12], 5) * 10 + lim(v[11:8], 9);
    hun  = lim(v[7:4], 9) * 10 + lim(v[3:0], 9);
    return mins * 6000 + secs * 100 + hun;
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit tk, nr;
    if (rst) begin
      m_t = 0; m_div = 0; m_lap_t = 0;
      m_run = 0; m_lap_act = 0; m_wrap = 0; m_done = 0;
    end else if (clear) begin
      m_t = 0; m_div = 0; m_lap_t = 0;
      m_run = 0; m_lap_act = 0; m_wrap = 0; m_done = 0;
    end else begin
      m_wrap = 0;
      tk = m_run && (m_div == CLK_DIV - 1);
      if (load && !m_run) begin
        m_t = from_load(load_val);
        m_div = 0; m_lap_act = 0; m_done = 0;
      end else begin
        nr = m_run;
        if (m_run) m_div = tk ? 0 : m_div + 1;
        if (tk) begin
          if (!dir) begin
            if (m_t == TMAX) begin m_t = 0; m_wrap = 1; end
            else m_t = m_t + 1;
          end else begin
            m_t = (m_t == 0) ? TMAX : m_t - 1;
            if (m_t == 0) begin nr = 0; m_done = 1; end
          end
        end
        if (start_stop) begin
          if (m_run) nr = 0;
          else if (!(dir && m_t == 0)) begin nr = 1; m_done = 0; end
        end
        if (lap) begin
          if (m_run) begin m_lap_t = m_t; m_lap_act = 1; end
          else m_lap_act = 0;
        end
        m_run = nr;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("disp", disp, to_bcd(m_lap_act ? m_lap_t : m_t));
      check("running", {23'd0, running}, {23'd0, m_run});
      check("lap_active", {23'd0, lap_active}, {23'd0, m_lap_act});
      check("wrapped", {23'd0, wrapped}, {23'd0, m_wrap});
      check("done", {23'd0, done}, {23'd0, m_done});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_stop = 1'b1; cyc(1); start_stop = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; cyc(1); clear = 1'b0;
  endtask

  task automatic do_lap();
    lap = 1'b1; cyc(1); lap = 1'b0;
  endtask

  task automatic do_load(input logic [23:0] v);
    load_val = v; load = 1'b1; cyc(1); load = 1'b0;
  endtask

  initial begin
    cyc(1);
    chk_en = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("reset_disp", disp, 24'h000000);
    check("reset_flags", {20'd0, running, lap_active, wrapped, done}, 24'd0);

    // Run and stop.
    do_start();
    cyc(400);
    check("run_1s", disp, 24'h000100);
    check("run_running", {23'd0, running}, 24'd1);
    do_start();
    cyc(40);
    check("stop_hold", disp, 24'h000100);
    check("stop_running", {23'd0, running}, 24'd0);

    // Cascade and up-count rollover.
    do_load(24'h095998);
    do_start();
    cyc(8);
    check("cascade", disp, 24'h100000);
    do_start();
    do_load(24'h995999);
    do_start();
    cyc(3);
    check("pre_wrap", {23'd0, wrapped}, 24'd0);
    cyc(1);
    check("wrap_disp", disp, 24'h000000);
    check("wrap_pulse", {23'd0, wrapped}, 24'd1);
    check("wrap_running", {23'd0, running}, 24'd1);
    cyc(1);
    check("wrap_one_cycle", {23'd0, wrapped}, 24'd0);
    do_start();

    // Count-down expiry.
    dir = 1'b1;
    do_load(24'h000002);
    do_start();
    cyc(8);
    check("down_disp", disp, 24'h000000);
    check("down_done", {23'd0, done}, 24'd1);
    check("down_stopped", {23'd0, running}, 24'd0);
    do_start();
    check("down_restart_ignored", {23'd0, running}, 24'd0);
    do_clear();
    check("clear_done", {23'd0, done}, 24'd0);
    dir = 1'b0;

    // Lap / split.
    do_start();
    cyc(200);
    do_lap();
    cyc(40);
    check("lap_frozen", disp, 24'h000050);
    check("lap_active", {23'd0, lap_active}, 24'd1);
    cyc(238);
    do_start();
    check("lap_still_frozen", disp, 24'h000050);
    do_lap();
    check("lap_release", disp, 24'h000120);
    check("lap_released", {23'd0, lap_active}, 24'd0);

    // Load guards and clamping.
    do_start();
    do_load(24'h000005);
    check("load_while_running", disp, 24'h000120);
    do_start();
    do_load(24'hFF7999);
    check("load_clamp", disp, 24'h995999);

    // Clear beats start_stop.
    clear = 1'b1; start_stop = 1'b1;
    cyc(1);
    clear = 1'b0; start_stop = 1'b0;
    check("clear_prio_disp", disp, 24'h000000);
    check("clear_prio_running", {23'd0, running}, 24'd0);

    // Direction change mid-run.
    do_load(24'h000003);
    do_start();
    cyc(8);
    check("dir_up", disp, 24'h000005);
    dir = 1'b1;
    cyc(8);
    check("dir_down", disp, 24'h000003);

    // Reset on a tick cycle while a lap is held.
    do_lap();
    cyc(2);
    check("pre_rst_lap", {23'd0, lap_active}, 24'd1);
    rst = 1'b1;
    cyc(1);
    check("rst_disp", disp, 24'h000000);
    check("rst_flags", {20'd0, running, lap_active, wrapped, done}, 24'd0);
    rst = 1'b0;
    dir = 1'b0;
    cyc(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd_counter.md
Name: stopwatch_bcd_counter

Overview:
- Complete stopwatch time base: divides clk to a 1/100 s tick and keeps a six-digit BCD time MM:SS.hh with full digit cascade.
- Counts up or down, supports run/stop, lap/split capture, preset load and a count-down expiry flag.
- Feeds the display/mux stage directly.
- Parametrised successor to the per-digit stopwatch counters: one block owns all digits and carries.

Parameters:
- CLK_DIV, 500000, clk cycles per 1/100 s tick (50 MHz -> 100 Hz); must be >= 2.
- DIV_W, 19, width of the tick divider; must satisfy 2^DIV_W >= CLK_DIV.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  one-cycle pulse: zero time, stop, release lap, clear done.
- start_stop  in  1  one-cycle pulse: toggle running.
- lap  in  1  one-cycle pulse: capture split while running / release while stopped.
- dir  in  1  0 = count up, 1 = count down; sampled on every tick.
- load  in  1  one-cycle pulse: preset time from load_val; honoured only when stopped.
- load_val  in  24  BCD preset {m_tens, m_units, s_tens, s_units, tenths, hundredths}, 4 bits each.
- disp  out  24  displayed time, same packing as load_val (s_tens upper bit always 0).
- running  out  1  counter active.
- lap_active  out  1  disp is showing the frozen split.
- wrapped  out  1  one-cycle pulse on up-count rollover 99:59.99 -> 00:00.00.
- done  out  1  sticky; count-down reached 00:00.00.

Behaviour:
- Reset: all digits 0, divider 0, running=0, lap_active=0, wrapped=0, done=0, disp=0.
- Digit moduli, low to high: hundredths 10, tenths 10, s_units 10, s_tens 6, m_units 10, m_tens 10. s_tens is held in a 3-bit register.
- Divider:
  - Counts 0..CLK_DIV-1 only while running; holds its value while stopped, so pause/resume loses no partial tick.
  - Zeroed by rst, clear and load.
  - tick=1 for one cycle when the divider equals CLK_DIV-1 and running=1.
- Up count on tick:
  - Increment hundredths. Each digit at its modulus-1 wraps to 0 and carries into the next digit.
  - At 99:59.99 all digits go to 0, wrapped pulses for one cycle, and running stays 1.
- Down count on tick:
  - Decrement with borrow. A digit at 0 borrows and becomes modulus-1.
  - The tick that produces 00:00.00 also sets running=0 and done=1 on the same edge.
- start_stop:
  - Toggles running.
  - While stopped with dir=1, time=00:00.00 the pulse is ignored and running stays 0.
  - Any start also clears done.
- Same-cycle start_stop and tick while running: the tick update is applied and running clears on the same edge.
- Priority, highest first: rst > clear > load > start_stop/tick > lap.
- load:
  - Accepted only when running=0; ignored while running.
  - Digits >9 clamp to 9; s_tens >5 clamps to 5.
  - Releases lap and clears done.
- lap:
  - With running=1: capture the current count into the lap register (the post-tick value if a tick occurs the same cycle) and set lap_active=1. A repeat pulse re-captures (split).
  - With running=0: lap_active=0.
- disp = lap_active ? lap register : live count. Purely combinational from registers, so disp shows a tick's result on the clk edge after the tick cycle.
- dir change mid-run takes effect on the next tick, with no glitch or skipped digit.
- clear mid-count or during lap: everything returns to the reset values except the divider-independent parameters.

Test Plan:
- CLK_DIV=4. Run: rst, start_stop pulse, 400 clk -> disp=00:01.00, running=1; second start_stop pulse then 40 idle clk -> disp unchanged.
- Cascade: load 09:59.98, start, 2 ticks -> 10:00.00; load 99:59.99, start, 1 tick -> 00:00.00, wrapped high exactly 1 cycle, running=1.
- Down: dir=1, load 00:00.02, start, 2 ticks -> 00:00.00, done=1, running=0. A further start_stop is ignored (running=0). Then clear -> done=0.
- Lap: running from 00:00.00, lap at 00:00.50 -> disp frozen at 00:00.50 while the live count continues. Stop at 00:01.20, lap -> disp=00:01.20, lap_active=0.
- Guards: load 00:00.05 while running -> ignored. Load while stopped with load_val digits {F,F,7,9,9,9} -> disp=99:59.99.
- Priority: clear and start_stop in the same cycle -> zero time, running=0. rst asserted mid-count on a tick cycle -> all outputs 0 on the next edge.
